// File: rtl/axis_stream_monitor_if.sv
// ----------------------------------------------------------------------------
// axis_stream_monitor_if
//
// AXI-stream bundle for one monitored stream.
//
// Handshake: a beat transfers on a rising clk edge where tvalid and tready are
// both high. Once tvalid is raised, the sender holds tvalid, tdata, tkeep and
// tlast stable until that transfer. The receiver may raise or lower tready
// freely unless the receiver-hold rule is being monitored.
//
// Modports:
//   master  : drives tvalid/tdata/tkeep/tlast, observes tready
//   slave   : observes tvalid/tdata/tkeep/tlast, drives tready
//   monitor : observes everything (passive tap)
// ----------------------------------------------------------------------------
interface axis_stream_monitor_if #(
    parameter int BYTES = 4
) ();
    logic                 tvalid;
    logic                 tready;
    logic [8*BYTES-1:0]   tdata;
    logic [BYTES-1:0]     tkeep;
    logic                 tlast;

    modport master  (output tvalid, output tdata, output tkeep, output tlast, input  tready);
    modport slave   (input  tvalid, input  tdata, input  tkeep, input  tlast, output tready);
    modport monitor (input  tvalid, input  tdata, input  tkeep, input  tlast, input  tready);
endinterface

// File: rtl/axis_stream_monitor.sv
// ----------------------------------------------------------------------------
// axis_stream_monitor
//
// Passive AXI-stream tap. Flags sender-hold, receiver-hold and tkeep
// violations with sticky flags, detects an idle stream, and reports per
// packet the gzip CRC32, the byte count and a running packet count.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   s                  monitored stream (monitor modport, never driven)
//   err_clear          synchronous clear of the sticky error flags
//   err_sender_hold    sticky: sender changed/dropped signals while stalled
//   err_receiver_hold  sticky: tready dropped after rising without tvalid
//   err_keep           sticky: illegal tkeep on a handshake beat
//   idle               tvalid low for IDLE_TIMEOUT consecutive cycles
//   pkt_done           one-cycle pulse when pkt_crc32/pkt_bytes update
//   pkt_crc32          CRC32 of the last completed packet
//   pkt_bytes          byte count of the last completed packet (saturating)
//   pkt_count          completed packets since reset (wrapping)
// ----------------------------------------------------------------------------
module axis_stream_monitor #(
    parameter int BYTES        = 4,
    parameter int IDLE_TIMEOUT = 100000,
    parameter bit CHK_SENDER   = 1'b1,
    parameter bit CHK_RECEIVER = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    axis_stream_monitor_if.monitor  s,
    input  logic                    err_clear,
    output logic                    err_sender_hold,
    output logic                    err_receiver_hold,
    output logic                    err_keep,
    output logic                    idle,
    output logic                    pkt_done,
    output logic [31:0]             pkt_crc32,
    output logic [31:0]             pkt_bytes,
    output logic [31:0]             pkt_count
);
    localparam int             IW       = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0]  IDLE_MAX = IW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0]  IDLE_ONE = IW'(1);
    localparam logic [BYTES-1:0] KEEP_ONE = BYTES'(1);

    // One byte of reflected CRC32 (poly 0xEDB88320), LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    logic                 prev_stall_q, prev_stall_d;
    logic [8*BYTES-1:0]   prev_data_q,  prev_data_d;
    logic [BYTES-1:0]     prev_keep_q,  prev_keep_d;
    logic                 prev_last_q,  prev_last_d;
    logic                 prev_rdy_q,   prev_rdy_d;   // tready & ~tvalid last cycle
    logic [31:0]          crc_q,        crc_d;
    logic [31:0]          cnt_q,        cnt_d;
    logic [31:0]          pkt_crc_q,    pkt_crc_d;
    logic [31:0]          pkt_bytes_q,  pkt_bytes_d;
    logic [31:0]          pkt_count_q,  pkt_count_d;
    logic                 pkt_done_q,   pkt_done_d;
    logic                 err_snd_q,    err_snd_d;
    logic                 err_rcv_q,    err_rcv_d;
    logic                 err_keep_q,   err_keep_d;
    logic [IW-1:0]        idle_cnt_q,   idle_cnt_d;

    logic                 fire;
    logic                 sender_viol;
    logic                 recv_viol;
    logic                 keep_viol;
    logic [BYTES-1:0]     keep_inc;
    logic [31:0]          crc_nxt;
    logic [31:0]          n_kept;
    logic [32:0]          cnt_sum;
    logic [31:0]          cnt_nxt;

    always_comb begin
        fire     = s.tvalid & s.tready;
        keep_inc = s.tkeep + KEEP_ONE;

        sender_viol = prev_stall_q & (~s.tvalid | (s.tdata != prev_data_q) |
                                      (s.tkeep != prev_keep_q) | (s.tlast != prev_last_q));
        recv_viol   = prev_rdy_q & ~s.tready;
        // Low-contiguous keep means keep+1 has no bit in common with keep.
        keep_viol   = fire & ((s.tkeep == '0) | ((s.tkeep & keep_inc) != '0) |
                              (~s.tlast & (s.tkeep != '1)));

        // Kept lanes are folded in ascending lane order, even for illegal keeps.
        crc_nxt = crc_q;
        n_kept  = 32'd0;
        for (int i = 0; i < BYTES; i++) begin
            if (s.tkeep[i]) begin
                crc_nxt = crc_byte(crc_nxt, s.tdata[8*i +: 8]);
                n_kept  = n_kept + 32'd1;
            end
        end
        cnt_sum = {1'b0, cnt_q} + {1'b0, n_kept};
        cnt_nxt = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];

        prev_stall_d = s.tvalid & ~s.tready;
        prev_data_d  = s.tdata;
        prev_keep_d  = s.tkeep;
        prev_last_d  = s.tlast;
        prev_rdy_d   = s.tready & ~s.tvalid;

        crc_d        = crc_q;
        cnt_d        = cnt_q;
        pkt_crc_d    = pkt_crc_q;
        pkt_bytes_d  = pkt_bytes_q;
        pkt_count_d  = pkt_count_q;
        pkt_done_d   = 1'b0;
        if (fire) begin
            if (s.tlast) begin
                pkt_crc_d   = ~crc_nxt;
                pkt_bytes_d = cnt_nxt;
                pkt_count_d = pkt_count_q + 32'd1;
                pkt_done_d  = 1'b1;
                crc_d       = 32'hFFFF_FFFF;
                cnt_d       = 32'd0;
            end else begin
                crc_d       = crc_nxt;
                cnt_d       = cnt_nxt;
            end
        end

        // A new violation wins over a simultaneous clear.
        err_snd_d  = CHK_SENDER   ? (sender_viol | (err_snd_q & ~err_clear)) : 1'b0;
        err_rcv_d  = CHK_RECEIVER ? (recv_viol   | (err_rcv_q & ~err_clear)) : 1'b0;
        err_keep_d = keep_viol | (err_keep_q & ~err_clear);

        if (s.tvalid)                    idle_cnt_d = '0;
        else if (idle_cnt_q == IDLE_MAX) idle_cnt_d = idle_cnt_q;
        else                             idle_cnt_d = idle_cnt_q + IDLE_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_stall_q <= 1'b0;
            prev_data_q  <= '0;
            prev_keep_q  <= '0;
            prev_last_q  <= 1'b0;
            prev_rdy_q   <= 1'b0;
            crc_q        <= 32'hFFFF_FFFF;
            cnt_q        <= 32'd0;
            pkt_crc_q    <= 32'd0;
            pkt_bytes_q  <= 32'd0;
            pkt_count_q  <= 32'd0;
            pkt_done_q   <= 1'b0;
            err_snd_q    <= 1'b0;
            err_rcv_q    <= 1'b0;
            err_keep_q   <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            prev_stall_q <= prev_stall_d;
            prev_data_q  <= prev_data_d;
            prev_keep_q  <= prev_keep_d;
            prev_last_q  <= prev_last_d;
            prev_rdy_q   <= prev_rdy_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            pkt_crc_q    <= pkt_crc_d;
            pkt_bytes_q  <= pkt_bytes_d;
            pkt_count_q  <= pkt_count_d;
            pkt_done_q   <= pkt_done_d;
            err_snd_q    <= err_snd_d;
            err_rcv_q    <= err_rcv_d;
            err_keep_q   <= err_keep_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign err_sender_hold   = err_snd_q;
    assign err_receiver_hold = err_rcv_q;
    assign err_keep          = err_keep_q;
    assign idle              = (idle_cnt_q == IDLE_MAX);
    assign pkt_done          = pkt_done_q;
    assign pkt_crc32         = pkt_crc_q;
    assign pkt_bytes         = pkt_bytes_q;
    assign pkt_count         = pkt_count_q;
endmodule
